interfaccia_seriale_uscita: RTL and testbench

Character output stage between the sEP8 I/O bus and the outside world. Accepts bytes written by the CPU to its data port, buffers them in a small FIFO, and serializes each one onto a UART-style TX line as an 8N1 frame, LSB first. A status port lets software poll for free space and idle state, replacing the unbuffered, simulation-only character print interface.

---
 rtl/interfaccia_seriale_uscita.sv | 209 ++++++++++++++++++++
 tb/tb_interfaccia_seriale_uscita.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interfaccia_seriale_uscita.sv
// interfaccia_seriale_uscita: character output stage for the sEP8 I/O bus.
// CPU writes to the data port (a0=0) are queued in a DEPTH-entry FIFO and
// sent on txd as UART frames, LSB first, DIVISOR clocks per bit.
// The status port (a0=1) reports {parity_en, ovf, idle, not_full} in bits 3:0.
// Optional feature macro: PARITY_EN. When defined, frames are 8E1 (an even
// parity bit follows the data bits) and status bit3 reads 1. When undefined,
// frames are 8N1 and status bit3 reads 0.
//
// Bus handshake: one push per falling edge of the write strobe. The registered
// select level is compared with the current one, so a strobe held low for any
// number of cycles pushes exactly once, with d7_d0 sampled on the rising-select
// cycle. The status read is combinational; ovf clears once on each rising edge
// of the status-read select.
//
// The TX FSM state is held in the internal signal 'state' (type tx_state_t).
module interfaccia_seriale_uscita #(
    parameter int DEPTH   = 8,
    parameter int DIVISOR = 16
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic       s_,
    input  logic       ior_,
    input  logic       iow_,
    input  logic       a0,
    input  logic [7:0] d7_d0,
    output logic [7:0] d7_d0_out,
    output logic       txd,
    output logic       busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

`ifdef PARITY_EN
    localparam logic PAR_FLAG = 1'b1;
`else
    localparam logic PAR_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_t;

    tx_state_t state, state_nx;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          wr_sel, wr_q, rd_sel, rd_q;
    logic          push_req, push_ok, pop, ovf, ovf_set;
    logic          full, empty;
    logic [CW-1:0] bit_cnt;
    logic          bit_end;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bit;

    assign wr_sel   = !s_ && !iow_ && !a0;
    assign rd_sel   = !s_ && !ior_ && a0;
    assign push_req = wr_sel && !wr_q;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign bit_end  = (bit_cnt == CW'(DIVISOR - 1));
    assign busy     = !empty || (state != IDLE);

    // Strobe edge detectors and the sticky overflow flag (a new overflow beats a clear).
    always_ff @(posedge clock) begin
        if (reset_) begin
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            wr_q <= wr_sel;
            rd_q <= rd_sel;
            if (ovf_set)
                ovf <= 1'b1;
            else if (rd_sel && !rd_q)
                ovf <= 1'b0;
        end
    end

    // FIFO storage; no reset needed since count guards every read.
    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wr_ptr] <= d7_d0;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // TX next-state logic and pop requests.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                if (bit_end)
                    state_nx = DATA;
            end
            DATA: begin
                if (bit_end && bit_idx == 3'd7)
`ifdef PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = STOP;
`endif
            end
`ifdef PARITY_EN
            PARITY: begin
                if (bit_end)
                    state_nx = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // TX state register, bit timer, data shifter and parity capture.
    always_ff @(posedge clock) begin
        if (reset_) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            par_bit <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE || bit_end)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + CW'(1);
            if (pop) begin
                shreg   <= mem[rd_ptr];
                par_bit <= ^mem[rd_ptr];
            end else if (state == DATA && bit_end) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Serial line level for the current state.
    always_comb begin
        txd = 1'b1;
        case (state)
            START:   txd = 1'b0;
            DATA:    txd = shreg[0];
`ifdef PARITY_EN
            PARITY:  txd = par_bit;
`endif
            default: txd = 1'b1;
        endcase
    end

    // Read mux: status on a0=1, zero for the data port and when unselected.
    always_comb begin
        d7_d0_out = 8'h00;
        if (rd_sel)
            d7_d0_out = {4'b0000, PAR_FLAG, ovf, empty && (state == IDLE), !full};
    end

`ifndef PARITY_EN
    logic unused_par;
    assign unused_par = par_bit;
`endif

endmodule

// File: tb/tb_interfaccia_seriale_uscita.sv
// Testbench for interfaccia_seriale_uscita: directed bus writes/reads, a
// line receiver that decodes frames against an expected-byte queue, and
// cycle-exact checks of start latency, bit levels and frame length.
module tb_interfaccia_seriale_uscita;

    localparam int DEPTH = 8;
    localparam int DIV   = 16;
`ifdef PARITY_EN
    localparam int         NB  = 11;
    localparam logic [7:0] PAR = 8'h08;
`else
    localparam int         NB  = 10;
    localparam logic [7:0] PAR = 8'h00;
`endif
    localparam logic [7:0] ST_IDLE = 8'h03 | PAR;

    logic       clock;
    logic       reset_;
    logic       s_, ior_, iow_, a0;
    logic [7:0] d7_d0;
    logic [7:0] d7_d0_out;
    logic       txd, busy;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    int         rx_frames = 0;

    interfaccia_seriale_uscita #(.DEPTH(DEPTH), .DIVISOR(DIV)) dut (
        .clock     (clock),
        .reset_    (reset_),
        .s_        (s_),
        .ior_      (ior_),
        .iow_      (iow_),
        .a0        (a0),
        .d7_d0     (d7_d0),
        .d7_d0_out (d7_d0_out),
        .txd       (txd),
        .busy      (busy)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus write: strobe held for 'hold' cycles, then one released cycle.
    task automatic io_write(input logic [7:0] b, input logic a, input int hold);
        s_ = 1'b0; a0 = a; iow_ = 1'b0; d7_d0 = b;
        repeat (hold) @(negedge clock);
        iow_ = 1'b1; s_ = 1'b1; a0 = 1'b0;
        @(negedge clock);
    endtask

    task automatic read_status(output logic [7:0] v);
        s_ = 1'b0; ior_ = 1'b0; a0 = 1'b1;
        #1 v = d7_d0_out;
        @(negedge clock);
        s_ = 1'b1; ior_ = 1'b1; a0 = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    // Single write with exact latency, per-bit levels and frame length checks.
    task automatic trace_frame(input logic [7:0] b);
        logic [NB-1:0] fr;
`ifdef PARITY_EN
        fr = {1'b1, ^b, b, 1'b0};
`else
        fr = {1'b1, b, 1'b0};
`endif
        exp_q.push_back(b);
        s_ = 1'b0; a0 = 1'b0; iow_ = 1'b0; d7_d0 = b;
        @(negedge clock);
        iow_ = 1'b1; s_ = 1'b1;
        check("pre_start_txd", txd, 1'b1);
        @(negedge clock);
        check("start_latency", txd, 1'b0);
        repeat (DIV / 2) @(negedge clock);
        for (int k = 0; k < NB; k++) begin
            check($sformatf("bit%0d_%0h", k, b), txd, fr[k]);
            if (k < NB - 1) repeat (DIV) @(negedge clock);
        end
        repeat (NB * DIV - 1 - (DIV / 2 + DIV * (NB - 1))) @(negedge clock);
        check("busy_last_cycle", busy, 1'b1);
        @(negedge clock);
        check("busy_after_frame", busy, 1'b0);
    endtask

    // Line receiver: samples mid-bit, compares against the expected queue.
    initial begin
        logic       rx_active;
        int         rx_cnt;
        int         k;
        logic [7:0] rx_byte;
        rx_active = 1'b0;
        rx_cnt = 0;
        rx_byte = 8'h00;
        forever begin
            @(negedge clock);
            if (reset_) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (txd === 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % DIV == DIV / 2) begin
                    k = rx_cnt / DIV;
                    if (k == 0) begin
                        check("rx_start", txd, 1'b0);
                    end else if (k <= 8) begin
                        rx_byte[k-1] = txd;
`ifdef PARITY_EN
                    end else if (k == 9) begin
                        check("rx_parity", txd, ^rx_byte);
`endif
                    end else begin
                        check("rx_stop", txd, 1'b1);
                        if (exp_q.size() == 0)
                            check("rx_unexpected_frame", exp_q.size(), 1);
                        else
                            check("rx_byte", rx_byte, exp_q.pop_front());
                        rx_frames++;
                        rx_active = 1'b0;
                    end
                end
            end
        end
    end

    // Main sequence
    initial begin
        logic [7:0] st;
        int         frames_before;
        int         low_cnt;

        reset_ = 1'b1; s_ = 1'b1; ior_ = 1'b1; iow_ = 1'b1; a0 = 1'b0; d7_d0 = 8'h00;
        repeat (3) @(negedge clock);
        check("reset_txd", txd, 1'b1);
        check("reset_busy", busy, 1'b0);
        reset_ = 1'b0;
        repeat (50) @(negedge clock);
        check("idle_txd", txd, 1'b1);
        check("idle_busy", busy, 1'b0);
        check("no_select_out", d7_d0_out, 8'h00);
        read_status(st);
        check("idle_status", st, ST_IDLE);

        // Data-port read returns zero
        s_ = 1'b0; ior_ = 1'b0; a0 = 1'b0;
        #1 check("data_port_read", d7_d0_out, 8'h00);
        @(negedge clock);
        s_ = 1'b1; ior_ = 1'b1;
        @(negedge clock);

        // Write to the status address is ignored
        io_write(8'hEE, 1'b1, 1);
        repeat (5) @(negedge clock);
        check("a0_write_busy", busy, 1'b0);
        read_status(st);
        check("a0_write_status", st, ST_IDLE);

        // Single frame, exact timing
        trace_frame(8'h41);
        read_status(st);
        check("after_41_status", st, ST_IDLE);

        // Back-to-back "Hi"
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        io_write(8'h48, 1'b0, 1);
        check("hi_start", txd, 1'b0);
        io_write(8'h69, 1'b0, 1);
        repeat (NB * DIV - 1 - 2) @(negedge clock);
        check("hi_stop_bit", txd, 1'b1);
        @(negedge clock);
        check("hi_second_start", txd, 1'b0);
        wait_idle("hi_idle", 3 * NB * DIV);
        check("hi_queue_empty", exp_q.size(), 0);

        // Overflow: DEPTH+2 bytes with no drain gaps
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i < DEPTH + 1) exp_q.push_back(8'h30 + 8'(i));
            io_write(8'h30 + 8'(i), 1'b0, 1);
        end
        read_status(st);
        check("ovf_status_first", st, 8'h04 | PAR);
        read_status(st);
        check("ovf_status_cleared", st, 8'h00 | PAR);
        wait_idle("ovf_idle", (DEPTH + 2) * NB * DIV);
        check("ovf_queue_empty", exp_q.size(), 0);
        read_status(st);
        check("ovf_final_status", st, ST_IDLE);

        // Long strobe: exactly one frame
        frames_before = rx_frames;
        exp_q.push_back(8'h5A);
        io_write(8'h5A, 1'b0, 40);
        wait_idle("long_idle", 3 * NB * DIV);
        repeat (NB * DIV) @(negedge clock);
        check("long_one_frame", rx_frames - frames_before, 1);
        check("long_queue_empty", exp_q.size(), 0);

        // Reset mid data bit with 3 bytes queued
        exp_q.push_back(8'h11);
        io_write(8'h11, 1'b0, 1);
        io_write(8'h22, 1'b0, 1);
        io_write(8'h33, 1'b0, 1);
        io_write(8'h44, 1'b0, 1);
        repeat (40) @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);
        check("midreset_txd", txd, 1'b1);
        check("midreset_busy", busy, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset_ = 1'b0;
        frames_before = rx_frames;
        low_cnt = 0;
        for (int i = 0; i < 5 * NB * DIV; i++) begin
            @(negedge clock);
            if (txd !== 1'b1) low_cnt++;
        end
        check("midreset_no_frames", rx_frames - frames_before, 0);
        check("midreset_line_high", low_cnt, 0);
        read_status(st);
        check("midreset_status", st, ST_IDLE);

`ifdef PARITY_EN
        trace_frame(8'h07);
        read_status(st);
        check("parity_status", st, ST_IDLE);
`endif

        repeat (DIV) @(negedge clock);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
